// File: rtl/maxpool_window_reader.sv
// Consumer for the 2x2 max-pool line buffer: captures one window, reduces it to its
// maximum, offers the result on a valid/ready stream and then steps the buffer pointer.
module maxpool_window_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_WIDTH = 8,
  parameter int KERNEL_SIZE = 2,
  parameter int STRIDE      = 2,
  parameter int SIGNED      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_window,
  input  logic [0:1][0:1][DATA_WIDTH-1:0]       window,
  output logic                                  win_update,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_last,
  output logic                                  row_pair_done,
  output logic                                  busy
);

  localparam int NUM_WIN = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1;
  localparam int CNT_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_WIN - 1);

  typedef enum logic [2:0] {IDLE, CMP, RES, OUT, SETTLE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                col_cnt;
  logic [0:1][0:1][DATA_WIDTH-1:0] w_p0;
  logic [DATA_WIDTH-1:0]           r0_p1;
  logic [DATA_WIDTH-1:0]           r1_p1;

  // Ties return either operand; both carry the same value so the choice is invisible.
  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) return (sa > sb) ? a : b;
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      col_cnt       <= '0;
      w_p0          <= '0;
      r0_p1         <= '0;
      r1_p1         <= '0;
      win_update    <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      row_pair_done <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        // p0: capture the whole window; later buffer changes are ignored
        IDLE: begin
          if (valid_window) begin
            w_p0  <= window;
            busy  <= 1'b1;
            state <= CMP;
          end
        end
        // p1: row-wise maxima
        CMP: begin
          r0_p1 <= max2(w_p0[0][0], w_p0[0][1]);
          r1_p1 <= max2(w_p0[1][0], w_p0[1][1]);
          state <= RES;
        end
        // p2: final maximum presented on the output stream
        RES: begin
          out_data  <= max2(r0_p1, r1_p1);
          out_valid <= 1'b1;
          out_last  <= (col_cnt == LAST_COL);
          state     <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            win_update <= 1'b1;
            if (col_cnt == LAST_COL) begin
              col_cnt       <= '0;
              row_pair_done <= 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            state <= SETTLE;
          end
        end
        // Buffer registers its new pointer during this cycle before re-sampling.
        SETTLE: begin
          win_update    <= 1'b0;
          row_pair_done <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_window_reader.sv
// Bench for maxpool_window_reader: a simple line-buffer model feeds windows, and each
// pooled pixel is checked against a 2x2-block maximum computed from the loaded rows.
module tb_maxpool_window_reader;

  logic                   clk;
  logic                   rst;
  logic                   valid_window;
  logic [0:1][0:1][15:0]  window;
  logic                   out_ready;
  logic                   win_update, out_valid, out_last, row_pair_done, busy;
  logic [15:0]            out_data;
  logic                   win_update_u, out_valid_u, out_last_u, row_pair_done_u, busy_u;
  logic [15:0]            out_data_u;

  logic [15:0] bufm [0:1][0:7];
  int          ptr;
  bit          loaded;
  int          vectors;
  int          miscompares;

  maxpool_window_reader #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .KERNEL_SIZE(2),
                          .STRIDE(2), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .valid_window(valid_window), .window(window),
    .win_update(win_update), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .row_pair_done(row_pair_done),
    .busy(busy));

  maxpool_window_reader #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .KERNEL_SIZE(2),
                          .STRIDE(2), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .valid_window(valid_window), .window(window),
    .win_update(win_update_u), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_data(out_data_u), .out_last(out_last_u), .row_pair_done(row_pair_done_u),
    .busy(busy_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line-buffer model: window starts at column ptr, valid while a full window fits.
  assign valid_window = loaded && (ptr <= 6);
  always_comb begin
    window = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (ptr <= 6) window[r][c] = bufm[r][ptr + c];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Maximum of output window k, compared as plain integers.
  function automatic logic [15:0] ref_max(input int k, input bit sgn);
    int best_v;
    logic [15:0] best_x;
    best_v = 0;
    best_x = '0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] x;
      int v;
      x = bufm[i / 2][2 * k + (i % 2)];
      v = sgn ? int'($signed(x)) : int'(x);
      if (i == 0 || v > best_v) begin
        best_v = v;
        best_x = x;
      end
    end
    return best_x;
  endfunction

  task automatic run_pair(input int stall, input int abort_at);
    int n, cyc, stall_left;
    bit acc_prev, last_prev, aborted;
    logic [15:0] es [4];
    logic [15:0] eu [4];
    for (int k = 0; k < 4; k++) begin
      es[k] = ref_max(k, 1'b1);
      eu[k] = ref_max(k, 1'b0);
    end
    n = 0; cyc = 0; stall_left = stall;
    acc_prev = 0; last_prev = 0; aborted = 0;
    ptr = 0; loaded = 1; out_ready = 1'b1;
    while ((n < 4 || acc_prev) && cyc < 200 && !aborted) begin
      @(negedge clk);
      cyc++;
      chk("win_update", win_update, acc_prev);
      chk("win_update_u", win_update_u, acc_prev);
      chk("row_pair_done", row_pair_done, acc_prev && last_prev);
      chk("row_pair_done_u", row_pair_done_u, acc_prev && last_prev);
      if (win_update) ptr += 2;
      acc_prev = 0;
      if (out_valid && n < 4) begin
        if (n == abort_at) begin
          rst = 1'b0;
          #1;
          chk("rst_out_valid", out_valid, 0);
          chk("rst_out_data", out_data, 0);
          chk("rst_out_last", out_last, 0);
          chk("rst_win_update", win_update, 0);
          chk("rst_row_pair_done", row_pair_done, 0);
          chk("rst_busy", busy, 0);
          chk("rst_out_valid_u", out_valid_u, 0);
          @(negedge clk);
          chk("rst_hold_win_update", win_update, 0);
          rst = 1'b1;
          aborted = 1;
        end else begin
          chk("out_data", out_data, es[n]);
          chk("out_data_u", out_data_u, eu[n]);
          chk("out_last", out_last, n == 3);
          chk("out_last_u", out_last_u, n == 3);
          if (n == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
            acc_prev  = 1;
            last_prev = (n == 3);
            n++;
          end
        end
      end
    end
    if (!aborted && (n < 4 || acc_prev)) chk("pair_timeout", n, 4);
    loaded = 0;
    out_ready = 1'b1;
  endtask

  task automatic load_ramp(input int base0, input int base1);
    for (int c = 0; c < 8; c++) begin
      bufm[0][c] = 16'(base0 + c + 1);
      bufm[1][c] = 16'(base1 + c + 1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    loaded = 0;
    ptr = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) bufm[r][c] = '0;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_win_update", win_update, 0);
    chk("reset_busy", busy, 0);
    chk("reset_row_pair_done", row_pair_done, 0);
    rst = 1'b1;

    // No window offered: everything must stay quiet.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_win_update", win_update, 0);
    end

    load_ramp(0, 100);
    run_pair(0, -1);
    load_ramp(0, 100);
    run_pair(3, -1);
    load_ramp(0, 100);
    run_pair(0, 1);
    repeat (3) @(negedge clk);
    chk("post_abort_busy", busy, 0);
    load_ramp(0, 100);
    run_pair(0, -1);
    load_ramp(200, 300);
    run_pair(0, -1);

    // Sign boundary: signed max is 0x0003, unsigned max is 0x8000.
    for (int c = 0; c < 8; c++) begin
      bufm[0][c] = 16'($urandom);
      bufm[1][c] = 16'($urandom);
    end
    bufm[0][0] = 16'h8000; bufm[0][1] = 16'h0001;
    bufm[1][0] = 16'h0002; bufm[1][1] = 16'h0003;
    chk("sign_ref_signed", ref_max(0, 1'b1), 32'h0003);
    chk("sign_ref_unsigned", ref_max(0, 1'b0), 32'h8000);
    run_pair(0, -1);

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 8; c++) begin
        bufm[0][c] = 16'($urandom);
        bufm[1][c] = 16'($urandom);
      end
      run_pair(int'($urandom_range(0, 4)), -1);
    end

    repeat (3) @(negedge clk);
    chk("final_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
